// File: rtl/himax_pkg.sv
// Shared types and default geometry for the Himax pixel-bus transmitter.
// Holds the timing state enum, default 324x324 geometry and nibble order.
package himax_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    LINE,
    HBLK,
    TRAIL,
    VBLK
  } px_tx_state_e;

  localparam int DEF_H_ACTIVE = 324;
  localparam int DEF_V_ACTIVE = 324;
  localparam int DEF_H_BLANK  = 16;
  localparam int DEF_V_LEAD   = 8;
  localparam int DEF_V_TRAIL  = 8;
  localparam int DEF_V_BLANK  = 64;

  localparam logic NIB_HI_FIRST = 1'b1;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // first=1 selects the nibble sent on the first of the two pixel clocks
  function automatic logic [3:0] nib_sel(
    input logic [7:0] b,
    input logic       first
  );
    return (first == NIB_HI_FIRST) ? b[7:4] : b[3:0];
  endfunction

endpackage

// File: rtl/himax_px_tx_pattern.sv
// Test-pattern byte generator: (x + y + frame) mod 256.
// Only present when HIMAX_PX_TX_TESTPAT_EN is defined.
`ifdef HIMAX_PX_TX_TESTPAT_EN
module himax_px_tx_pattern (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [7:0] frame,
  output logic [7:0] pix
);

  assign pix = x + y + frame;

endmodule
`endif

// File: rtl/himax_px_tx.sv
// Himax-style pixel-bus transmitter: fv/lv framing, 8-bit pixels as 2 nibbles.
// HIMAX_PX_TX_TESTPAT_EN adds a test_pat input and an internal pattern source.
module himax_px_tx
  import himax_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int H_BLANK  = DEF_H_BLANK,
  parameter int V_LEAD   = DEF_V_LEAD,
  parameter int V_TRAIL  = DEF_V_TRAIL,
  parameter int V_BLANK  = DEF_V_BLANK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        px_fv,
  output logic        px_lv,
  output logic [3:0]  pxd,
  output logic        frame_done,
  output logic        underflow,
  input  logic        clr_err,
`ifdef HIMAX_PX_TX_TESTPAT_EN
  input  logic        test_pat,
`endif
  output logic [15:0] frame_cnt
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BW = cnt_width(H_BLANK, V_LEAD, V_TRAIL, V_BLANK);

  localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] B_LEAD  = BW'(V_LEAD - 1);
  localparam logic [BW-1:0] B_HBLK  = BW'(H_BLANK - 1);
  localparam logic [BW-1:0] B_TRAIL = BW'(V_TRAIL - 1);
  localparam logic [BW-1:0] B_VBLK  = BW'(V_BLANK - 1);

  px_tx_state_e  state_q, state_n;
  logic [BW-1:0] bcnt_q, bcnt_n;
  logic [XW-1:0] x_q, x_n;
  logic [YW-1:0] y_q, y_n;
  logic          ph_q, ph_n;
  logic          done_n;
  logic          fetch_q, fetch_n;
  logic [3:0]    lo_q;
  logic [7:0]    pix;
  logic          miss;
  logic          pat_q, pat_d;
  logic [7:0]    pat_byte;

`ifdef HIMAX_PX_TX_TESTPAT_EN
  logic [7:0] fx;

  assign fx = (state_q == LINE) ? 8'(x_q) + 8'd1 : 8'd0;

  himax_px_tx_pattern u_pat (
    .x     (fx),
    .y     (8'(y_q)),
    .frame (frame_cnt[7:0]),
    .pix   (pat_byte)
  );

  // Source only switches between frames
  assign pat_d = (state_q == IDLE || state_q == VBLK) ?
                 test_pat : pat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pat_q <= 1'b0;
    else     pat_q <= pat_d;
  end
`else
  assign pat_d    = 1'b0;
  assign pat_q    = 1'b0;
  assign pat_byte = 8'h00;
`endif

  assign pix  = pat_q ? pat_byte : (s_valid ? s_data : 8'h00);
  assign miss = ~pat_q & ~s_valid;

  always_comb begin
    state_n = state_q;
    bcnt_n  = bcnt_q;
    x_n     = x_q;
    y_n     = y_q;
    ph_n    = ph_q;
    done_n  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_n = LEAD;
          bcnt_n  = '0;
        end
      end
      LEAD: begin
        if (bcnt_q == B_LEAD) begin
          state_n = LINE;
          bcnt_n  = '0;
          x_n     = '0;
          y_n     = '0;
          ph_n    = 1'b0;
        end else begin
          bcnt_n = bcnt_q + 1'b1;
        end
      end
      LINE: begin
        ph_n = ~ph_q;
        if (ph_q) begin
          if (x_q == X_LAST) begin
            x_n    = '0;
            bcnt_n = '0;
            if (y_q == Y_LAST) begin
              state_n = TRAIL;
              y_n     = '0;
            end else begin
              state_n = HBLK;
              y_n     = y_q + 1'b1;
            end
          end else begin
            x_n = x_q + 1'b1;
          end
        end
      end
      HBLK: begin
        if (bcnt_q == B_HBLK) begin
          state_n = LINE;
          bcnt_n  = '0;
        end else begin
          bcnt_n = bcnt_q + 1'b1;
        end
      end
      TRAIL: begin
        if (bcnt_q == B_TRAIL) begin
          state_n = VBLK;
          bcnt_n  = '0;
          done_n  = 1'b1;
        end else begin
          bcnt_n = bcnt_q + 1'b1;
        end
      end
      VBLK: begin
        if (bcnt_q == B_VBLK) begin
          state_n = en ? LEAD : IDLE;
          bcnt_n  = '0;
        end else begin
          bcnt_n = bcnt_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A fetch cycle is the one right before every hi-nibble cycle
  always_comb begin
    fetch_n = 1'b0;
    if (state_n == LEAD && bcnt_n == B_LEAD) fetch_n = 1'b1;
    if (state_n == HBLK && bcnt_n == B_HBLK) fetch_n = 1'b1;
    if (state_n == LINE && ph_n && x_n != X_LAST) fetch_n = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bcnt_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      ph_q       <= 1'b0;
      fetch_q    <= 1'b0;
      lo_q       <= '0;
      s_ready    <= 1'b0;
      px_fv      <= 1'b0;
      px_lv      <= 1'b0;
      pxd        <= '0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state_q    <= state_n;
      bcnt_q     <= bcnt_n;
      x_q        <= x_n;
      y_q        <= y_n;
      ph_q       <= ph_n;
      fetch_q    <= fetch_n;
      s_ready    <= fetch_n & ~pat_d;
      px_fv      <= (state_n != IDLE) && (state_n != VBLK);
      px_lv      <= (state_n == LINE);
      frame_done <= done_n;
      if (done_n) frame_cnt <= frame_cnt + 16'd1;
      if (fetch_q) begin
        pxd  <= nib_sel(pix, 1'b1);
        lo_q <= nib_sel(pix, 1'b0);
      end else if (state_n == LINE) begin
        pxd <= lo_q;
      end else begin
        pxd <= '0;
      end
      if (clr_err)            underflow <= 1'b0;
      else if (fetch_q & miss) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_himax_px_tx.sv
// Scoreboard bench for himax_px_tx on a 4x2 bench geometry.
// Covers framing, underflow, en drop, async reset, back-to-back frames.
module tb_himax_px_tx;

  localparam int HA = 4;
  localparam int VA = 2;
  localparam int HB = 3;
  localparam int VL = 2;
  localparam int VT = 2;
  localparam int VB = 5;
  localparam int FV_LEN = VL + VA * 2 * HA + (VA - 1) * HB + VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [7:0]  s_data = 8'h10;
  logic        s_valid = 1'b1;
  logic        s_ready;
  logic        px_fv;
  logic        px_lv;
  logic [3:0]  pxd;
  logic        frame_done;
  logic        underflow;
  logic        clr_err = 1'b0;
  logic [15:0] frame_cnt;
`ifdef HIMAX_PX_TX_TESTPAT_EN
  logic        test_pat = 1'b0;
`endif

  himax_px_tx #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .H_BLANK  (HB),
    .V_LEAD   (VL),
    .V_TRAIL  (VT),
    .V_BLANK  (VB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .px_fv      (px_fv),
    .px_lv      (px_lv),
    .pxd        (pxd),
    .frame_done (frame_done),
    .underflow  (underflow),
    .clr_err    (clr_err),
`ifdef HIMAX_PX_TX_TESTPAT_EN
    .test_pat   (test_pat),
`endif
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  int  pix_idx = 0;
  int  drop_idx = -1;
  bit  advance = 1'b0;

  int  done_cnt, rdy_cnt, fv_rises, pix_seen;
  int  fv_len, low_len, lv_len, gap, lv_pulses;
  int  gap_checks;
  bit  prev_fv, prev_lv, have_fall, ph;
  logic [3:0] hi;
  logic [7:0] exp_b;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stream source: push the byte the DUT is about to take
  always @(negedge clk) begin
    if (advance) begin
      pix_idx++;
      s_data  = 8'h10 + 8'(pix_idx);
      s_valid = (pix_idx != drop_idx);
      advance = 1'b0;
    end
    if (s_ready) begin
      sb.push_back(s_valid ? s_data : 8'h00);
      advance = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_fv = 0; prev_lv = 0; have_fall = 0; ph = 0;
      fv_len = 0; low_len = 0; lv_len = 0; gap = 0;
      lv_pulses = 0; done_cnt = 0; rdy_cnt = 0;
      fv_rises = 0; pix_seen = 0; gap_checks = 0;
      sb.delete();
    end else begin
      if (frame_done) done_cnt++;
      if (s_ready) rdy_cnt++;
      check("done_at_fall", 32'(frame_done),
            32'(!px_fv && prev_fv));
      if (px_fv && !prev_fv) begin
        if (have_fall) begin
          check("fv_gap", low_len, VB);
          gap_checks++;
        end
        fv_len = 0;
        lv_pulses = 0;
        fv_rises++;
      end
      if (!px_fv && prev_fv) begin
        check("fv_len", fv_len, FV_LEN);
        check("lv_pulses", lv_pulses, VA);
        have_fall = 1;
        low_len = 0;
      end
      if (px_fv) fv_len++;
      else       low_len++;
      if (px_lv && !prev_lv && lv_pulses > 0)
        check("hblank", gap, HB);
      if (!px_lv && prev_lv) begin
        check("lv_len", lv_len, 2 * HA);
        lv_pulses++;
        gap = 0;
      end
      if (px_lv) begin
        if (!prev_lv) begin
          lv_len = 0;
          ph = 0;
        end
        lv_len++;
        if (!ph) begin
          hi = pxd;
        end else if (sb.size() == 0) begin
          check("sb_empty", 1, 0);
        end else begin
          exp_b = sb.pop_front();
          check("pixel", {24'h0, hi, pxd}, {24'h0, exp_b});
          pix_seen++;
        end
        ph = ~ph;
      end else begin
        check("pxd_idle", pxd, 0);
        if (px_fv) gap++;
      end
      prev_fv = px_fv;
      prev_lv = px_lv;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    clr_err = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    advance = 1'b0;
    pix_idx = 0;
    s_data  = 8'h10;
    s_valid = (drop_idx != 0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int n, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt >= n) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic wait_lv(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (px_lv) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("lv_timeout", 0, 1);
  endtask

  initial begin
    // 1: single frame, reset state first
    drop_idx = -1;
    do_reset();
    check("rst_fv", px_fv, 0);
    check("rst_lv", px_lv, 0);
    check("rst_pxd", pxd, 0);
    check("rst_rdy", s_ready, 0);
    check("rst_done", frame_done, 0);
    check("rst_uf", underflow, 0);
    check("rst_cnt", frame_cnt, 0);
    en = 1'b1;
    wait_cycles(2);
    en = 1'b0;
    wait_done(1, 60);
    wait_cycles(8);
    check("t1_done", done_cnt, 1);
    check("t1_cnt", frame_cnt, 1);
    check("t1_pix", pix_seen, 2 * HA);
    check("t1_sb", sb.size(), 0);
    check("t1_uf", underflow, 0);

    // 2: missing pixel at line0 pixel2
    drop_idx = 2;
    do_reset();
    en = 1'b1;
    wait_cycles(2);
    en = 1'b0;
    wait_done(1, 60);
    wait_cycles(8);
    check("t2_uf", underflow, 1);
    check("t2_pix", pix_seen, 2 * HA);
    check("t2_rises", fv_rises, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("t2_clr", underflow, 0);

    // 3: en dropped during line 0
    drop_idx = -1;
    do_reset();
    en = 1'b1;
    wait_lv(30);
    en = 1'b0;
    wait_done(1, 60);
    wait_cycles(30);
    check("t3_rises", fv_rises, 1);
    check("t3_cnt", frame_cnt, 1);
    check("t3_fv", px_fv, 0);
    check("t3_pix", pix_seen, 2 * HA);

    // 4: async reset mid-line
    do_reset();
    en = 1'b1;
    wait_lv(30);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t4_fv", px_fv, 0);
    check("t4_lv", px_lv, 0);
    check("t4_pxd", pxd, 0);
    check("t4_rdy", s_ready, 0);
    repeat (2) @(negedge clk);
    #1;
    advance = 1'b0;
    rst = 1'b0;
    wait_cycles(2);
    en = 1'b0;
    wait_done(1, 60);
    wait_cycles(8);
    check("t4_cnt", frame_cnt, 1);
    check("t4_pix", pix_seen, 2 * HA);
    check("t4_sb", sb.size(), 0);

    // 5: three back-to-back frames
    do_reset();
    en = 1'b1;
    wait_done(3, 200);
    en = 1'b0;
    wait_cycles(20);
    check("t5_done", done_cnt, 3);
    check("t5_cnt", frame_cnt, 3);
    check("t5_rises", fv_rises, 3);
    check("t5_gaps", gap_checks, 2);
    check("t5_pix", pix_seen, 6 * HA);
    check("t5_sb", sb.size(), 0);

`ifdef HIMAX_PX_TX_TESTPAT_EN
    // 6: internal pattern, two frames
    do_reset();
    test_pat = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int y = 0; y < VA; y++)
        for (int x = 0; x < HA; x++)
          sb.push_back(8'(x + y + f));
    en = 1'b1;
    wait_done(2, 120);
    en = 1'b0;
    wait_cycles(20);
    check("t6_rdy", rdy_cnt, 0);
    check("t6_uf", underflow, 0);
    check("t6_pix", pix_seen, 4 * HA);
    check("t6_sb", sb.size(), 0);
    check("t6_cnt", frame_cnt, 2);
    test_pat = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
